// File: rtl/memory_access_stage_pkg.sv
// Shared Y86-64 definitions for the memory access stage: status codes,
// instruction codes, the "no register" id and the request FSM encoding.
package memory_access_stage_pkg;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic {
    REQ_IDLE = 1'b0,
    REQ_WAIT = 1'b1
  } req_state_e;

endpackage

// File: rtl/memory_access_stage_dmem_req_fsm.sv
// Data-memory request sequencer: issues one valid/ready request per M-stage
// instruction, waits for the response and remembers it until M advances.
module dmem_req_fsm
  import memory_access_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en,
  input  logic        advance,
  input  logic        req_ready,
  input  logic        rsp_valid,
  input  logic [63:0] rsp_rdata,
  input  logic        rsp_err,
  output logic        req_valid,
  output logic        busy,
  output logic        rsp_now,
  output logic        done,
  output logic        err_q,
  output logic [63:0] rdata_q
);

  req_state_e state;
  req_state_e state_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= REQ_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      REQ_IDLE: if (req_valid && req_ready) state_next = REQ_WAIT;
      REQ_WAIT: if (rsp_valid) state_next = REQ_IDLE;
      default:  state_next = REQ_IDLE;
    endcase
  end

  // A pending access holds the request until accepted; busy drops in the
  // response cycle so the W register can capture the data directly.
  always_comb begin
    req_valid = (state == REQ_IDLE) && req_en && !done;
    rsp_now   = (state == REQ_WAIT) && rsp_valid;
    busy      = req_valid || ((state == REQ_WAIT) && !rsp_valid);
  end

  // done blocks a re-issue while M is held; a new instruction clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 64'd0;
    end else begin
      if (rsp_now) begin
        rdata_q <= rsp_rdata;
        err_q   <= rsp_err;
      end
      if (advance) begin
        done <= 1'b0;
      end else if (rsp_now) begin
        done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/memory_access_stage.sv
// Y86-64 memory access stage: decodes the M register, drives the data-memory
// port, produces m_stat/m_valM and holds the M->W pipeline register.
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int unsigned DMEM_BYTES = 8192
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  M_stat_i,
  input  logic [3:0]  M_icode_i,
  input  logic [63:0] M_valE_i,
  input  logic [63:0] M_valA_i,
  input  logic [3:0]  M_dstE_i,
  input  logic [3:0]  M_dstM_i,
  input  logic        m_advance_i,
  output logic        dmem_req_valid_o,
  input  logic        dmem_req_ready_i,
  output logic        dmem_req_we_o,
  output logic [63:0] dmem_req_addr_o,
  output logic [63:0] dmem_req_wdata_o,
  input  logic        dmem_rsp_valid_i,
  input  logic [63:0] dmem_rsp_rdata_i,
  input  logic        dmem_rsp_err_i,
  output logic        m_busy_o,
  output logic [2:0]  m_stat_o,
  output logic [63:0] m_valM_o,
  input  logic        W_stall_i,
  input  logic        W_bubble_i,
  output logic [2:0]  W_stat_o,
  output logic [3:0]  W_icode_o,
  output logic [63:0] W_valE_o,
  output logic [63:0] W_valM_o,
  output logic [3:0]  W_dstE_o,
  output logic [3:0]  W_dstM_o
);

  localparam logic [63:0] ADDR_MAX = 64'(DMEM_BYTES) - 64'd8;

  logic        is_read;
  logic        is_write;
  logic [63:0] addr;
  logic        addr_ok;
  logic        mem_op;
  logic        rsp_now;
  logic        done;
  logic        err_q;
  logic [63:0] rdata_q;

  // Any address beyond the last full quad, including wrapped values, faults.
  always_comb begin
    is_read  = (M_icode_i == IMRMOVQ) || (M_icode_i == IPOPQ) || (M_icode_i == IRET);
    is_write = (M_icode_i == IRMMOVQ) || (M_icode_i == IPUSHQ) || (M_icode_i == ICALL);
    addr     = ((M_icode_i == IPOPQ) || (M_icode_i == IRET)) ? M_valA_i : M_valE_i;
    addr_ok  = (addr <= ADDR_MAX);
    mem_op   = (is_read || is_write) && (M_stat_i == SAOK) && addr_ok;
  end

  dmem_req_fsm u_req_fsm (
    .clk       (clk_i),
    .rst       (rst_i),
    .req_en    (mem_op),
    .advance   (m_advance_i),
    .req_ready (dmem_req_ready_i),
    .rsp_valid (dmem_rsp_valid_i),
    .rsp_rdata (dmem_rsp_rdata_i),
    .rsp_err   (dmem_rsp_err_i),
    .req_valid (dmem_req_valid_o),
    .busy      (m_busy_o),
    .rsp_now   (rsp_now),
    .done      (done),
    .err_q     (err_q),
    .rdata_q   (rdata_q)
  );

  always_comb begin
    dmem_req_we_o    = is_write;
    dmem_req_addr_o  = addr;
    dmem_req_wdata_o = M_valA_i;
  end

  // Upstream faults win over address faults, which win over memory faults.
  always_comb begin
    m_stat_o = SAOK;
    if (M_stat_i != SAOK) begin
      m_stat_o = M_stat_i;
    end else if ((is_read || is_write) && !addr_ok) begin
      m_stat_o = SADR;
    end else if ((rsp_now && dmem_rsp_err_i) || (done && err_q)) begin
      m_stat_o = SADR;
    end
  end

  always_comb begin
    m_valM_o = 64'd0;
    if (is_read && rsp_now) begin
      m_valM_o = dmem_rsp_rdata_i;
    end else if (is_read && done) begin
      m_valM_o = rdata_q;
    end
  end

  // Bubble takes priority over stall; busy also holds the register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      W_stat_o  <= SAOK;
      W_icode_o <= INOP;
      W_valE_o  <= 64'd0;
      W_valM_o  <= 64'd0;
      W_dstE_o  <= RNONE;
      W_dstM_o  <= RNONE;
    end else if (W_bubble_i) begin
      W_stat_o  <= SAOK;
      W_icode_o <= INOP;
      W_valE_o  <= 64'd0;
      W_valM_o  <= 64'd0;
      W_dstE_o  <= RNONE;
      W_dstM_o  <= RNONE;
    end else if (!W_stall_i && !m_busy_o) begin
      W_stat_o  <= m_stat_o;
      W_icode_o <= M_icode_i;
      W_valE_o  <= M_valE_i;
      W_valM_o  <= m_valM_o;
      W_dstE_o  <= M_dstE_i;
      W_dstM_o  <= M_dstM_i;
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed self-checking bench for memory_access_stage: reads, writes,
// address faults, held-M behaviour, reset mid-access and W bubble priority.
module tb_memory_access_stage;
  import memory_access_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  M_stat;
  logic [3:0]  M_icode;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic        m_advance;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        m_busy;
  logic [2:0]  m_stat;
  logic [63:0] m_valM;
  logic        W_stall;
  logic        W_bubble;
  logic [2:0]  W_stat;
  logic [3:0]  W_icode;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;

  int checkCount = 0;
  int failCount  = 0;
  int reqCount   = 0;
  int reqBefore;

  memory_access_stage #(.DMEM_BYTES(8192)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .M_stat_i         (M_stat),
    .M_icode_i        (M_icode),
    .M_valE_i         (M_valE),
    .M_valA_i         (M_valA),
    .M_dstE_i         (M_dstE),
    .M_dstM_i         (M_dstM),
    .m_advance_i      (m_advance),
    .dmem_req_valid_o (req_valid),
    .dmem_req_ready_i (req_ready),
    .dmem_req_we_o    (req_we),
    .dmem_req_addr_o  (req_addr),
    .dmem_req_wdata_o (req_wdata),
    .dmem_rsp_valid_i (rsp_valid),
    .dmem_rsp_rdata_i (rsp_rdata),
    .dmem_rsp_err_i   (rsp_err),
    .m_busy_o         (m_busy),
    .m_stat_o         (m_stat),
    .m_valM_o         (m_valM),
    .W_stall_i        (W_stall),
    .W_bubble_i       (W_bubble),
    .W_stat_o         (W_stat),
    .W_icode_o        (W_icode),
    .W_valE_o         (W_valE),
    .W_valM_o         (W_valM),
    .W_dstE_o         (W_dstE),
    .W_dstM_o         (W_dstM)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && req_valid && req_ready) reqCount <= reqCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] stat, input logic [3:0] icode,
                               input logic [63:0] valE, input logic [63:0] valA,
                               input logic [3:0] dstE, input logic [3:0] dstM);
    M_stat  = stat;
    M_icode = icode;
    M_valE  = valE;
    M_valA  = valA;
    M_dstE  = dstE;
    M_dstM  = dstM;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(SAOK, INOP, 64'd0, 64'd0, RNONE, RNONE);
    m_advance = 1'b1;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = 64'd0;
    rsp_err   = 1'b0;
    W_stall   = 1'b0;
    W_bubble  = 1'b0;
    #12;
    checkOutput("rst_W_stat", 64'(W_stat), 64'(SAOK));
    checkOutput("rst_W_icode", 64'(W_icode), 64'(INOP));
    checkOutput("rst_W_dstE", 64'(W_dstE), 64'(RNONE));
    checkOutput("rst_W_valM", W_valM, 64'd0);
    checkOutput("rst_busy", 64'(m_busy), 64'd0);
    rst = 1'b0;
    tick();

    // mrmovq: accepted at once, response after two WAIT cycles
    applyStimulus(SAOK, IMRMOVQ, 64'h100, 64'd0, RNONE, 4'h3);
    m_advance = 1'b0;
    req_ready = 1'b1;
    #1;
    checkOutput("rd_valid", 64'(req_valid), 64'd1);
    checkOutput("rd_we", 64'(req_we), 64'd0);
    checkOutput("rd_addr", req_addr, 64'h100);
    checkOutput("rd_busy1", 64'(m_busy), 64'd1);
    checkOutput("rd_W_hold", 64'(W_icode), 64'(INOP));
    tick();
    req_ready = 1'b0;
    #1;
    checkOutput("rd_wait_valid", 64'(req_valid), 64'd0);
    checkOutput("rd_busy2", 64'(m_busy), 64'd1);
    tick();
    checkOutput("rd_busy3", 64'(m_busy), 64'd1);
    tick();
    rsp_valid = 1'b1;
    rsp_rdata = 64'hDEAD;
    m_advance = 1'b1;
    #1;
    checkOutput("rd_busy_rsp", 64'(m_busy), 64'd0);
    checkOutput("rd_valM", m_valM, 64'hDEAD);
    checkOutput("rd_stat", 64'(m_stat), 64'(SAOK));
    tick();
    rsp_valid = 1'b0;
    m_advance = 1'b0;
    #1;
    checkOutput("rd_W_valM", W_valM, 64'hDEAD);
    checkOutput("rd_W_stat", 64'(W_stat), 64'(SAOK));
    checkOutput("rd_W_icode", 64'(W_icode), 64'(IMRMOVQ));
    checkOutput("rd_W_dstM", 64'(W_dstM), 64'h3);
    checkOutput("adv_rsp_reissue", 64'(req_valid), 64'd1);
    applyStimulus(SAOK, INOP, 64'd0, 64'd0, RNONE, RNONE);
    m_advance = 1'b1;
    tick();

    // pushq with ready held low for two cycles
    reqBefore = reqCount;
    applyStimulus(SAOK, IPUSHQ, 64'h1F8, 64'h55, 4'h4, RNONE);
    m_advance = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("wr_valid", 64'(req_valid), 64'd1);
      checkOutput("wr_we", 64'(req_we), 64'd1);
      checkOutput("wr_addr", req_addr, 64'h1F8);
      checkOutput("wr_wdata", req_wdata, 64'h55);
      if (i < 2) tick();
    end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    #1;
    checkOutput("wr_wait_valid", 64'(req_valid), 64'd0);
    checkOutput("wr_single_req", 64'(reqCount - reqBefore), 64'd1);
    rsp_valid = 1'b1;
    rsp_rdata = 64'hBAD;
    m_advance = 1'b1;
    #1;
    checkOutput("wr_valM_zero", m_valM, 64'd0);
    tick();
    rsp_valid = 1'b0;
    applyStimulus(SAOK, INOP, 64'd0, 64'd0, RNONE, RNONE);
    #1;
    checkOutput("wr_W_icode", 64'(W_icode), 64'(IPUSHQ));
    checkOutput("wr_W_valE", W_valE, 64'h1F8);
    checkOutput("wr_W_valM", W_valM, 64'd0);

    // popq address boundaries
    applyStimulus(SAOK, IPOPQ, 64'h0, 64'd8185, 4'h4, 4'h2);
    #1;
    checkOutput("pop_bad_valid", 64'(req_valid), 64'd0);
    checkOutput("pop_bad_busy", 64'(m_busy), 64'd0);
    checkOutput("pop_bad_stat", 64'(m_stat), 64'(SADR));
    tick();
    checkOutput("pop_bad_W_stat", 64'(W_stat), 64'(SADR));
    checkOutput("pop_bad_W_icode", 64'(W_icode), 64'(IPOPQ));
    applyStimulus(SAOK, IPOPQ, 64'h0, 64'd8184, 4'h4, 4'h2);
    m_advance = 1'b0;
    #1;
    checkOutput("pop_ok_valid", 64'(req_valid), 64'd1);
    checkOutput("pop_ok_addr", req_addr, 64'd8184);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_rdata = 64'h77;
    m_advance = 1'b1;
    tick();
    rsp_valid = 1'b0;
    applyStimulus(SAOK, IPOPQ, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, 4'h4, 4'h2);
    #1;
    checkOutput("pop_ok_W_valM", W_valM, 64'h77);
    checkOutput("pop_wrap_valid", 64'(req_valid), 64'd0);
    checkOutput("pop_wrap_stat", 64'(m_stat), 64'(SADR));
    tick();

    // upstream SINS suppresses the access; memory error maps to SADR
    applyStimulus(SINS, IRMMOVQ, 64'h40, 64'h9, RNONE, RNONE);
    #1;
    checkOutput("sins_valid", 64'(req_valid), 64'd0);
    checkOutput("sins_stat", 64'(m_stat), 64'(SINS));
    tick();
    checkOutput("sins_W_stat", 64'(W_stat), 64'(SINS));
    applyStimulus(SAOK, IMRMOVQ, 64'h40, 64'd0, RNONE, 4'h1);
    m_advance = 1'b0;
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_err   = 1'b1;
    m_advance = 1'b1;
    #1;
    checkOutput("err_stat", 64'(m_stat), 64'(SADR));
    tick();
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    #1;
    checkOutput("err_W_stat", 64'(W_stat), 64'(SADR));

    // response while M and W are held: no re-issue, m_valM from the capture
    applyStimulus(SAOK, IMRMOVQ, 64'h80, 64'd0, RNONE, 4'h5);
    m_advance = 1'b0;
    W_stall   = 1'b1;
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_rdata = 64'h1234;
    #1;
    checkOutput("hold_rsp_busy", 64'(m_busy), 64'd0);
    tick();
    rsp_valid = 1'b0;
    reqBefore = reqCount;
    for (int i = 0; i < 3; i++) begin
      checkOutput("hold_valid", 64'(req_valid), 64'd0);
      checkOutput("hold_busy", 64'(m_busy), 64'd0);
      checkOutput("hold_valM", m_valM, 64'h1234);
      checkOutput("hold_W_stat", 64'(W_stat), 64'(SADR));
      tick();
    end
    checkOutput("hold_no_reissue", 64'(reqCount - reqBefore), 64'd0);
    W_stall   = 1'b0;
    m_advance = 1'b1;
    tick();
    applyStimulus(SAOK, INOP, 64'd0, 64'd0, RNONE, RNONE);
    #1;
    checkOutput("hold_W_valM", W_valM, 64'h1234);
    checkOutput("hold_W_stat_ok", 64'(W_stat), 64'(SAOK));
    checkOutput("hold_W_dstM", 64'(W_dstM), 64'h5);

    // reset while waiting for a response, then a stray response
    applyStimulus(SAOK, IMRMOVQ, 64'h10, 64'd0, RNONE, 4'h6);
    m_advance = 1'b0;
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    #1;
    checkOutput("rst_wait_busy", 64'(m_busy), 64'd1);
    rst = 1'b1;
    applyStimulus(SAOK, INOP, 64'd0, 64'd0, RNONE, RNONE);
    #1;
    checkOutput("rst_mid_W_icode", 64'(W_icode), 64'(INOP));
    checkOutput("rst_mid_W_valM", W_valM, 64'd0);
    checkOutput("rst_mid_busy", 64'(m_busy), 64'd0);
    tick();
    rst = 1'b0;
    rsp_valid = 1'b1;
    rsp_rdata = 64'hFFFF;
    #1;
    checkOutput("stray_busy", 64'(m_busy), 64'd0);
    checkOutput("stray_valM", m_valM, 64'd0);
    tick();
    rsp_valid = 1'b0;
    applyStimulus(SAOK, IMRMOVQ, 64'h20, 64'd0, RNONE, 4'h7);
    #1;
    checkOutput("stray_no_done", 64'(req_valid), 64'd1);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_rdata = 64'hAB;
    m_advance = 1'b1;
    tick();
    rsp_valid = 1'b0;
    applyStimulus(SAOK, INOP, 64'd0, 64'd0, RNONE, RNONE);
    #1;
    checkOutput("post_rst_W_valM", W_valM, 64'hAB);

    // bubble and stall together: bubble wins
    W_stall  = 1'b1;
    W_bubble = 1'b1;
    tick();
    W_stall  = 1'b0;
    W_bubble = 1'b0;
    #1;
    checkOutput("bubble_W_icode", 64'(W_icode), 64'(INOP));
    checkOutput("bubble_W_valM", W_valM, 64'd0);
    checkOutput("bubble_W_dstM", 64'(W_dstM), 64'(RNONE));
    checkOutput("bubble_W_stat", 64'(W_stat), 64'(SAOK));

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
- Y86-64 pipeline M stage plus the M→W pipeline register.
- Consumes the M_* pipeline register outputs.
- Drives a valid/ready data-memory port for mrmovq/popq/ret reads and rmmovq/pushq/call writes.
- Raises a stall request while an access is outstanding, computes m_stat/m_valM, and registers results into the W stage.

Parameters:
- DMEM_BYTES, 8192, size of the data address space in bytes; a quad access is legal iff addr <= DMEM_BYTES-8.

Ports:
- clk_i in 1: clock
- rst_i in 1: reset, asynchronous, active-high
- M_stat_i in 3: status from the M register
- M_icode_i in 4: icode from the M register
- M_valE_i in 64: ALU result
- M_valA_i in 64: operand A, write data or pop address
- M_dstE_i in 4: destination register E
- M_dstM_i in 4: destination register M
- m_advance_i in 1: M register loads a new instruction at the next edge (~M_stall from the hazard unit)
- dmem_req_valid_o out 1: request valid
- dmem_req_ready_i in 1: request accepted
- dmem_req_we_o out 1: 1 for write, 0 for read
- dmem_req_addr_o out 64: access address
- dmem_req_wdata_o out 64: write data
- dmem_rsp_valid_i in 1: response valid
- dmem_rsp_rdata_i in 64: read data
- dmem_rsp_err_i in 1: access fault
- m_busy_o out 1: stall request to the hazard unit
- m_stat_o out 3: combinational M status, for hazard/exception logic
- m_valM_o out 64: combinational read data
- W_stall_i in 1: W register stall
- W_bubble_i in 1: W register bubble
- W_stat_o, W_icode_o, W_valE_o, W_valM_o, W_dstE_o, W_dstM_o out 3/4/64/64/4/4: W register outputs

Behaviour:
- Decode:
  - read = icode in {IMRMOVQ, IPOPQ, IRET}.
  - write = icode in {IRMMOVQ, IPUSHQ, ICALL}.
  - addr = M_valA_i for IPOPQ/IRET, otherwise M_valE_i.
  - wdata = M_valA_i.
- need_mem = (read|write) & M_stat_i==SAOK & addr legal & ~done.
- FSM states:
  - IDLE: when need_mem, drive dmem_req_valid_o with addr/we/wdata. If dmem_req_ready_i is also high, go to WAIT. Otherwise stay in IDLE with the request held stable; valid is never dropped before ready.
  - WAIT: dmem_req_valid_o=0. When dmem_rsp_valid_i is seen, capture rdata and err into rdata_q/err_q, set done, and go to IDLE.
- done flag:
  - Cleared at any edge where m_advance_i=1.
  - Prevents a second issue while M is held by other stalls.
- m_busy_o = need_mem | (state==WAIT & ~dmem_rsp_valid_i). Deasserts combinationally in the response cycle.
- m_valM_o:
  - In the response cycle, it is dmem_rsp_rdata_i.
  - When done is set, it is rdata_q.
  - Otherwise it is 0.
- m_stat_o, in priority order:
  1. M_stat_i if it is not SAOK.
  2. SADR if (read|write) and the address is illegal; no request is issued.
  3. SADR on a response with dmem_rsp_err_i=1, or when done is set and err_q=1.
  4. Otherwise SAOK.
- Writes return a response with ignored rdata; m_valM_o is then 0.
- W register (posedge clk_i):
  - W_bubble_i has priority: load stat=SAOK, icode=INOP, dstE=dstM=RNONE, data=0.
  - Otherwise, when ~W_stall_i & ~m_busy_o, load m_stat_o, M_icode_i, M_valE_i, m_valM_o, M_dstE_i, M_dstM_i.
  - Otherwise, hold.
- Reset: state=IDLE, done=0, rdata_q=0, err_q=0. W outputs take bubble values: stat SAOK, icode INOP, dstE/dstM RNONE, valE/valM 0.
- Reset mid-transaction abandons the access. The memory is reset by the same rst_i, and a late response after reset is ignored in IDLE.
- Simultaneous m_advance_i and response in the same cycle: done is not set; a new instruction may issue next cycle.
- Boundary addresses: DMEM_BYTES-8 is legal; DMEM_BYTES-7 raises SADR; a wrapped 64-bit address raises SADR.

Decomposition:
- Shared define package: stat codes SAOK/SHLT/SADR/SINS, icodes, RNONE, INOP. No new constants except the FSM state encoding.
- One natural sub-module, dmem_req_fsm: the IDLE/WAIT FSM, done flag and response capture.
- The decode logic and the W register stay in the top module.

Test Plan:
- mrmovq, valE=0x100, ready=1, response 2 cycles later with rdata=0xDEAD → busy for 3 cycles; W_valM_o=0xDEAD, W_stat_o=SAOK.
- pushq, valE=0x1F8, valA=0x55, ready low 2 cycles → valid/addr/wdata held stable; we=1; a single request issued.
- popq, valA=DMEM_BYTES-7 → no request, busy=0, W_stat_o=SADR; then valA=DMEM_BYTES-8 → request issued.
- rmmovq with M_stat_i=SINS → no request, W_stat_o=SINS; read with rsp_err=1 → W_stat_o=SADR.
- Response completes while m_advance_i=0 for 3 cycles (W stalled) → no reissue; m_valM_o holds rdata_q.
- rst_i asserted in WAIT → outputs at reset values immediately; stray rsp_valid ignored; W_bubble_i and W_stall_i both high → bubble wins.
